alu_issue_wb: RTL and testbench
===============================

# alu_issue_wb

Instruction issue and writeback controller that drives the registered 32-bit ALU stage and retires its results. It accepts 32-bit instruction words over a valid/ready handshake and decodes them against an internal 16 x 32 register file. It presents operands and a 4-bit opcode to the ALU for exactly one cycle, then captures the ALU result one cycle later and writes it to the destination register. The block sits between the instruction source and the ALU and closes the ALU's result path.

## Interface
- Parameters:
  - CNT_W, 16: width of the retired-instruction counter.
- Ports:
  - clk, input, 1: clock; all state updates on the rising edge.
  - rst, input, 1: reset; synchronous, active-high.
  - ins_valid, input, 1: instruction word on ins_data is valid.
  - ins_ready, output, 1: block can accept an instruction this cycle.
  - ins_data, input, 32: bits [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2; bits [15:0] ignored.
  - ld_en, input, 1: direct register load request, honoured only in IDLE.
  - ld_addr, input, 4: load target register.
  - ld_data, input, 32: load value.
  - alu_a, output, 32: operand A to ALU (registered).
  - alu_b, output, 32: operand B to ALU (registered).
  - alu_op, output, 4: opcode to ALU (registered).
  - alu_result, input, 32: registered ALU output.
  - retire, output, 1: one-cycle pulse on the cycle a writeback commits.
  - retired_cnt, output, CNT_W: count of retired instructions, wraps modulo 2^CNT_W.
  - dbg_addr, input, 4: debug read address.
  - dbg_data, output, 32: combinational read of reg[dbg_addr].

## Operation
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - ins_ready = !ld_en.
  - If ld_en: reg[ld_addr] <= ld_data, stay in IDLE.
  - Else if ins_valid: latch rd and opcode; load alu_a <= reg[rs1], alu_b <= reg[rs2], alu_op <= opcode; go to ISSUE.
- ISSUE:
  - alu_a, alu_b and alu_op are stable for this one cycle.
  - At the end of the cycle, the ALU samples them; alu_op <= 4'b0000.
  - Go to WB.
- WB:
  - alu_result is valid.
  - If the latched opcode is in 0001..1001, reg[rd] <= alu_result.
  - Opcodes 0000 and 1010..1111 are NOPs: no register write. The ALU holds its previous value for these opcodes.
  - retire = 1 for every instruction, NOP included; retired_cnt increments.
  - Go to IDLE.
- ins_ready is 0 in ISSUE and WB.
- alu_op is 0000 in every cycle other than ISSUE, so the ALU holds its output between instructions.
- Opcode 1001 shifts the ALU's current output left by 3 and ignores the operands. The controller issues it like any other opcode and writes back whatever alu_result shows in WB.
- No hazards are possible: writeback commits before the next instruction's register read in IDLE.
- Register file has no hardwired-zero register; all 16 are writable.
- Arithmetic is owned by the ALU. Results are the low 32 bits; multiply truncates and subtract wraps.

## Timing
- Reset values:
  - State IDLE.
  - All 16 registers 0.
  - alu_a, alu_b 0; alu_op 0000.
  - retire 0; retired_cnt 0.
  - ins_ready 1 in the first cycle after rst deasserts (if ld_en = 0).
- Latency: accept edge (cycle 0) → ISSUE (cycle 1) → WB (cycle 2), with the register write and retire pulse in cycle 2. The result is visible on dbg_data from cycle 3.
- Throughput: one instruction per 3 cycles. With ins_valid held high, accepts occur every third cycle.
- Handshake: an instruction transfers on the edge where ins_valid && ins_ready. ins_data need only be stable in that cycle.
- Reset mid-operation: rst in ISSUE or WB aborts the instruction.
  - No register write, no retire pulse, counter cleared.
  - rst takes priority over ld_en and writeback in the same cycle.
- Load and instruction in the same IDLE cycle: the load wins and the instruction is not accepted (ins_ready = 0).
- rd equal to rs1/rs2 is legal. Operands are read at accept, before writeback.

## Test plan
- Reset: assert rst 2 cycles with ins_valid = 1.
  - dbg_data = 0 for all 16 addresses.
  - alu_op = 0000, retired_cnt = 0.
  - ins_ready = 1 the cycle after release.
- ADD: load r1 = 7, r2 = 5; issue op 0001 rd = 3 rs1 = 1 rs2 = 2.
  - ISSUE cycle shows alu_a = 7, alu_b = 5, alu_op = 0001.
  - retire pulses in WB; r3 = 12; retired_cnt = 1.
- Wrap and truncation:
  - SUB rd = 4 = r2 − r1 → r4 = 0xFFFFFFFE.
  - Load r6 = r7 = 0x00010000; MUL rd = 8 = r6 * r7 → r8 = 0.
- Shift and NOP:
  - After the ADD giving 12, issue op 1001 rd = 5 → r5 = 96.
  - Issue op 1100 rd = 5 → r5 stays 96; retire pulses; counter increments.
- Back-to-back: hold ins_valid = 1 for 4 instructions.
  - Accepts occur exactly 3 cycles apart.
  - alu_op is 0000 outside ISSUE cycles.
  - retired_cnt = 4.
- Abort: assert rst during WB of ADD rd = 9.
  - r9 stays 0; no retire pulse.
  - State returns to IDLE with ins_ready = 1.

Source files
------------

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue/writeback controller for the registered 32-bit ALU.
// Accepts instruction words, reads operands from a 16 x 32 register file,
// drives the ALU for one cycle and writes the result back one cycle later.
//
// state | meaning
// IDLE  | accept a register load or an instruction
// ISSUE | operands/opcode on the ALU inputs for exactly one cycle
// WB    | alu_result valid; write back (unless NOP) and retire
module alu_issue_wb #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [31:0]       ins_data,
    input  logic              ld_en,
    input  logic [3:0]        ld_addr,
    input  logic [31:0]       ld_data,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_op,
    input  logic [31:0]       alu_result,
    output logic              retire,
    output logic [CNT_W-1:0]  retired_cnt,
    input  logic [3:0]        dbg_addr,
    output logic [31:0]       dbg_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] regs [16];
    logic [3:0]  rd_q;
    logic [3:0]  op_q;
    logic        op_writes;

    // A pending load blocks instruction acceptance in the same cycle.
    assign ins_ready = (state == IDLE) && !ld_en;

    // Retire is the WB state itself; a reset arriving during WB suppresses it.
    assign retire = (state == WB) && !rst;

    // Only opcodes 0001..1001 produce a result worth committing.
    assign op_writes = (op_q >= 4'd1) && (op_q <= 4'd9);

    // Debug port reads the register file combinationally.
    assign dbg_data = regs[dbg_addr];

    // Sequencer: register file, ALU drive, writeback and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rd_q        <= '0;
            op_q        <= '0;
            retired_cnt <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ld_en) begin
                        regs[ld_addr] <= ld_data;
                    end else if (ins_valid) begin
                        op_q   <= ins_data[31:28];
                        rd_q   <= ins_data[27:24];
                        alu_a  <= regs[ins_data[23:20]];
                        alu_b  <= regs[ins_data[19:16]];
                        alu_op <= ins_data[31:28];
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ALU samples the operands on this edge; park it afterwards.
                    alu_op <= 4'b0000;
                    state  <= WB;
                end
                WB: begin
                    if (op_writes) begin
                        regs[rd_q] <= alu_result;
                    end
                    retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed tests for alu_issue_wb with a behavioural
// registered ALU closing the result path.
module tb_alu_issue_wb;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ins_valid = 1'b0;
    logic              ins_ready;
    logic [31:0]       ins_data = '0;
    logic              ld_en = 1'b0;
    logic [3:0]        ld_addr = '0;
    logic [31:0]       ld_data = '0;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_op;
    logic [31:0]       alu_result;
    logic              retire;
    logic [CNT_W-1:0]  retired_cnt;
    logic [3:0]        dbg_addr = '0;
    logic [31:0]       dbg_data;

    int n_checks = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] exp_cnt;

    alu_issue_wb #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .retire      (retire),
        .retired_cnt (retired_cnt),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Registered ALU: holds its output for 0000 and 1010..1111.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
        end else begin
            case (alu_op)
                4'd1: alu_result <= alu_a + alu_b;
                4'd2: alu_result <= alu_a - alu_b;
                4'd3: alu_result <= alu_a * alu_b;
                4'd4: alu_result <= alu_a & alu_b;
                4'd5: alu_result <= alu_a | alu_b;
                4'd6: alu_result <= alu_a ^ alu_b;
                4'd7: alu_result <= alu_a << alu_b[4:0];
                4'd8: alu_result <= alu_a >> alu_b[4:0];
                4'd9: alu_result <= alu_result << 3;
                default: alu_result <= alu_result;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    // Drives one instruction through accept; returns at start of ISSUE.
    task automatic accept(input logic [3:0] op, input logic [3:0] rd,
                          input logic [3:0] rs1, input logic [3:0] rs2);
        ins_valid = 1'b1;
        ins_data  = {op, rd, rs1, rs2, 16'hBEEF};
        step();
        ins_valid = 1'b0;
        ins_data  = '0;
    endtask

    // Full instruction; returns at start of the cycle after WB.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs1, input logic [3:0] rs2);
        accept(op, rd, rs1, rs2);
        step();
        step();
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        ins_valid = 1'b1;
        ins_data  = {4'd1, 4'd3, 4'd1, 4'd2, 16'h0};
        step();
        step();
        rst = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        n_checks++;
        if (ins_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ins_ready: got %b expected 1", ins_ready);
        end
        n_checks++;
        if (alu_op !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_alu_op: got %h expected 0", alu_op);
        end
        n_checks++;
        if (retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected %0d", retired_cnt, exp_cnt);
        end
        n_checks++;
        if (retire !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_retire: got %b expected 0", retire);
        end
        ins_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            n_checks++;
            if (dbg_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected 0", i, dbg_data);
            end
        end
        step();
    endtask

    task automatic test_add;
        load(4'd1, 32'd7);
        // Load and instruction together: load wins, instruction waits.
        ld_en     = 1'b1;
        ld_addr   = 4'd2;
        ld_data   = 32'd5;
        ins_valid = 1'b1;
        ins_data  = {4'd1, 4'd3, 4'd1, 4'd2, 16'h1234};
        @(negedge clk);
        n_checks++;
        if (ins_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_blocks_ready: got %b expected 0", ins_ready);
        end
        step();
        ld_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ins_ready !== 1'b1 || alu_op !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_wins_idle: got ready=%b op=%h expected ready=1 op=0", ins_ready, alu_op);
        end
        step();
        ins_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (alu_a !== 32'd7 || alu_b !== 32'd5 || alu_op !== 4'd1) begin
            n_fail++;
            $display("FAIL add_issue: got a=%0d b=%0d op=%h expected a=7 b=5 op=1", alu_a, alu_b, alu_op);
        end
        n_checks++;
        if (ins_ready !== 1'b0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL add_issue_ctl: got ready=%b retire=%b expected 0 0", ins_ready, retire);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (retire !== 1'b1 || alu_op !== 4'b0000 || ins_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_wb: got retire=%b op=%h ready=%b expected 1 0 0", retire, alu_op, ins_ready);
        end
        step();
        exp_cnt++;
        dbg_addr = 4'd3;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'd12) begin
            n_fail++;
            $display("FAIL add_r3: got %0d expected 12", dbg_data);
        end
        n_checks++;
        if (retired_cnt !== exp_cnt || retire !== 1'b0 || ins_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_after: got cnt=%0d retire=%b ready=%b expected cnt=%0d 0 1", retired_cnt, retire, ins_ready, exp_cnt);
        end
        step();
    endtask

    task automatic test_wrap;
        run_instr(4'd2, 4'd4, 4'd2, 4'd1);
        exp_cnt++;
        dbg_addr = 4'd4;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL sub_wrap_r4: got %h expected fffffffe", dbg_data);
        end
        step();
        load(4'd6, 32'h0001_0000);
        load(4'd7, 32'h0001_0000);
        load(4'd8, 32'hDEAD_BEEF);
        run_instr(4'd3, 4'd8, 4'd6, 4'd7);
        exp_cnt++;
        dbg_addr = 4'd8;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mul_trunc_r8: got %h expected 0", dbg_data);
        end
        step();
        // rd equal to both sources: operands read before writeback.
        load(4'd10, 32'd3);
        run_instr(4'd1, 4'd10, 4'd10, 4'd10);
        exp_cnt++;
        dbg_addr = 4'd10;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'd6) begin
            n_fail++;
            $display("FAIL self_add_r10: got %0d expected 6", dbg_data);
        end
        n_checks++;
        if (retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_cnt: got %0d expected %0d", retired_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_shift_nop;
        run_instr(4'd1, 4'd3, 4'd1, 4'd2);
        exp_cnt++;
        run_instr(4'd9, 4'd5, 4'd0, 4'd0);
        exp_cnt++;
        dbg_addr = 4'd5;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'd96) begin
            n_fail++;
            $display("FAIL shift_r5: got %0d expected 96", dbg_data);
        end
        step();
        accept(4'hC, 4'd5, 4'd1, 4'd2);
        step();
        @(negedge clk);
        n_checks++;
        if (retire !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_retire: got %b expected 1", retire);
        end
        step();
        exp_cnt++;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'd96 || retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL nop_r5: got r5=%0d cnt=%0d expected 96 %0d", dbg_data, retired_cnt, exp_cnt);
        end
        step();
        // Opcode 0000 and the lowest NOP code must not write r2 (ALU shows 96).
        run_instr(4'h0, 4'd2, 4'd1, 4'd1);
        exp_cnt++;
        run_instr(4'hA, 4'd2, 4'd1, 4'd1);
        exp_cnt++;
        dbg_addr = 4'd2;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'd5 || retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL nop_bounds_r2: got r2=%0d cnt=%0d expected 5 %0d", dbg_data, retired_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back;
        logic acc;
        int   k;
        k = 0;
        ins_valid = 1'b1;
        ins_data  = {4'd1, 4'd11, 4'd1, 4'd2, 16'h0};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = ins_valid && ins_ready;
            n_checks++;
            if (acc !== ((c % 3 == 0) && (c <= 9))) begin
                n_fail++;
                $display("FAIL b2b_accept_c%0d: got %b expected %b", c, acc, ((c % 3 == 0) && (c <= 9)));
            end
            n_checks++;
            if (alu_op !== ((c % 3 == 1) ? 4'd1 : 4'd0)) begin
                n_fail++;
                $display("FAIL b2b_alu_op_c%0d: got %h expected %h", c, alu_op, ((c % 3 == 1) ? 4'd1 : 4'd0));
            end
            step();
            if (acc) begin
                k++;
                ins_data = {4'd1, 4'(11 + k), 4'd1, 4'd2, 16'h0};
                if (k == 4) ins_valid = 1'b0;
            end
        end
        exp_cnt = exp_cnt + 16'd4;
        @(negedge clk);
        n_checks++;
        if (retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d expected %0d", retired_cnt, exp_cnt);
        end
        for (int r = 11; r < 15; r++) begin
            dbg_addr = 4'(r);
            #1;
            n_checks++;
            if (dbg_data !== 32'd12) begin
                n_fail++;
                $display("FAIL b2b_r%0d: got %0d expected 12", r, dbg_data);
            end
        end
        step();
    endtask

    task automatic test_abort;
        accept(4'd1, 4'd9, 4'd1, 4'd2);
        step();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (retire !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_retire: got %b expected 0", retire);
        end
        step();
        rst = 1'b0;
        exp_cnt = '0;
        dbg_addr = 4'd9;
        @(negedge clk);
        n_checks++;
        if (dbg_data !== 32'h0 || retired_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL abort_state: got r9=%0d cnt=%0d expected 0 0", dbg_data, retired_cnt);
        end
        n_checks++;
        if (ins_ready !== 1'b1 || alu_op !== 4'b0000 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got ready=%b op=%h retire=%b expected 1 0 0", ins_ready, alu_op, retire);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_shift_nop();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
